bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Loadable multi-digit BCD down counter (countdown timer); the complement of the team's cascaded BCD up counter.
- Takes a packed BCD preset, decrements once per enabled clock with decimal borrow across digits, and flags terminal count.
- Sits beside the up counter in the timer/display datapath; its Out feeds the same 7-segment/display logic.

Parameters:
- DIGITS, 4, number of BCD digits; count width = 4*DIGITS.
- WRAP, 0, 0 = stop and hold at zero; 1 = wrap from zero to all-9s and keep running.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  load request, sampled every edge
- load_val  input  4*DIGITS  packed BCD preset; digit 0 in bits [3:0]
- enable  input  1  count-enable / pause
- Out  output  4*DIGITS  current count, packed BCD, registered
- zero  output  1  high while Out == 0, registered
- done  output  1  one-cycle pulse when the count reaches 0 by decrementing
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, and all state changes on the rising edge of clk.
- Reset values (reset has priority over everything): Out=0, zero=1, done=0, load_err=0, state=IDLE.
- States:
  - IDLE: no valid preset loaded; enable ignored.
  - RUN: counting.
  - DONE: terminal count reached (WRAP=0 only).
- Priority per edge: reset > load > enable.
- Load check: load=1 and every digit of load_val ≤ 9.
  - If valid: Out<=load_val next edge, from any state. Next state is RUN if load_val≠0, else DONE.
  - done is not pulsed by a load, even a load of 0.
- Invalid load: load=1 and any digit > 9.
  - Load is rejected: Out and state unchanged, load_err=1 for exactly one cycle.
  - No decrement occurs that cycle, even if enable=1.
- Decrement (RUN, enable=1, load=0): count decrements by 1 next edge.
  - Digit 0 always decrements; digit k decrements only when digits 0..k-1 were all 0.
  - A digit at 0 that decrements becomes 9.
  - All arithmetic is per digit, 4 bits wide. No binary carry between digits, and no non-BCD value ever appears on Out.
- RUN with enable=0: hold Out, no pulses.
- Count 0…01 → 0 in RUN: on the same edge Out becomes 0, zero=1 and done=1 for one cycle.
  - WRAP=0: next state DONE. DONE holds Out=0 and ignores enable; only load or reset leave it.
  - WRAP=1: stay in RUN. The next enabled edge sets Out to all-9s (9999 for DIGITS=4) with zero=0 and no pulse.
- Latency: zero is updated on the same edge as Out, so zero == (Out==0) on every cycle.
- done and load_err never assert on the same cycle. load and reset both force done=0.
- load arriving on the edge where the count would reach 0: load wins, done is not pulsed, Out=load_val.
- reset mid-count: next edge forces the reset values regardless of load or enable.
- Cycle budget: a preset N (decimal value) produces done exactly N enabled cycles after the load edge, with idle cycles (enable=0) not counted.

Test Plan:
- Reset, then load=1 with load_val=0x0003, then enable=1 continuously → Out 0003, 0002, 0001, 0000 on successive edges. done=1 only on the 0000 cycle; zero=1 from that cycle; state holds at 0000 for 5 more enabled cycles (WRAP=0).
- Load 0x1000, enable 1 cycle → Out=0x0999 (borrow across three digits). Load 0x0100, enable 1 cycle → 0x0099.
- Load 0x0A12 → load_err pulses 1 cycle and Out keeps its prior value. Load 0x0012 next → Out=0x0012, load_err=0.
- Load 0x0005, toggle enable 1,0,0,1,1,1,1 → done asserts on the 7th cycle after load (5th enabled cycle), with Out held during enable=0 cycles.
- WRAP=1: load 0x0001, enable → Out=0000 with done=1, then 9999 (zero=0, done=0), then 9998.
- Count at 0x0001 with enable=1 and load=1 (load_val=0x0042) on the same edge → Out=0x0042, done=0. Assert reset mid-count at 0x0037 with load=1 → Out=0, zero=1, state IDLE, and enable is ignored afterwards.

Source files
------------

// File: rtl/bcd_down_counter.sv
// Loadable packed-BCD down counter with per-digit borrow, terminal-count flag and load validation.
// Out/zero/done/load_err are all registered (one edge from load/enable); no backpressure, enable simply pauses.
module bcd_down_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  enable,
    output logic [4*DIGITS-1:0]   Out,
    output logic                  zero,
    output logic                  done,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   out_nxt;
    logic [W-1:0]   dec_val;
    logic           zero_nxt;
    logic           done_nxt;
    logic           err_nxt;
    logic           load_ok;
    logic           borrow;

    // Per-digit decrement: a digit only borrows when every lower digit was 0.
    always_comb begin
        dec_val = Out;
        borrow  = 1'b1;
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                dec_val[4*i +: 4] = (Out[4*i +: 4] == 4'd0) ? 4'd9 : Out[4*i +: 4] - 4'd1;
            end
            borrow = borrow && (Out[4*i +: 4] == 4'd0);
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = Out;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (load) begin
            if (load_ok) begin
                out_nxt   = load_val;
                state_nxt = (load_val == '0) ? DONE : RUN;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (enable && state == RUN) begin
            out_nxt = dec_val;
            // Wrapping from 0 yields all-9s, so only a real 1->0 step lands here.
            if (dec_val == '0) begin
                done_nxt  = 1'b1;
                state_nxt = WRAP ? RUN : DONE;
            end
        end
        zero_nxt = (out_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            Out      <= '0;
            zero     <= 1'b1;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            Out      <= out_nxt;
            zero     <= zero_nxt;
            done     <= done_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Drives a hold-at-zero and a wrapping counter with the same directed and random stimulus.
module tb_bcd_down_counter;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic        enable = 1'b0;

    logic [15:0] out0, out1;
    logic        zero0, zero1, done0, done1, err0, err1;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt [2];
    int m_st  [2];
    bit m_done[2];
    bit m_lerr[2];

    bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .enable(enable),
        .Out(out0), .zero(zero0), .done(done0), .load_err(err0)
    );

    bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .enable(enable),
        .Out(out1), .zero(zero1), .done(done1), .load_err(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          v;
        r = '0;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_valid(input logic [15:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [15:0] v);
        int s = 0;
        for (int i = DIGITS - 1; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
        return s;
    endfunction

    task automatic model_step(input int k, input logic r, input logic l,
                              input logic [15:0] v, input logic e);
        m_done[k] = 1'b0;
        m_lerr[k] = 1'b0;
        if (r) begin
            m_cnt[k] = 0;
            m_st[k]  = S_IDLE;
        end else if (l) begin
            if (bcd_valid(v)) begin
                m_cnt[k] = from_bcd(v);
                m_st[k]  = (m_cnt[k] == 0) ? S_DONE : S_RUN;
            end else begin
                m_lerr[k] = 1'b1;
            end
        end else if (e && m_st[k] == S_RUN) begin
            if (m_cnt[k] == 0) begin
                m_cnt[k] = MAXV;
            end else begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    m_done[k] = 1'b1;
                    if (k == 0) m_st[k] = S_DONE;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic [15:0] v, input logic e);
        reset    = r;
        load     = l;
        load_val = v;
        enable   = e;
        @(posedge clk);
        model_step(0, r, l, v, e);
        model_step(1, r, l, v, e);
        #1;
        check("hold_out",  32'(out0),  32'(to_bcd(m_cnt[0])));
        check("hold_zero", 32'(zero0), 32'(m_cnt[0] == 0));
        check("hold_done", 32'(done0), 32'(m_done[0]));
        check("hold_lerr", 32'(err0),  32'(m_lerr[0]));
        check("wrap_out",  32'(out1),  32'(to_bcd(m_cnt[1])));
        check("wrap_zero", 32'(zero1), 32'(m_cnt[1] == 0));
        check("wrap_done", 32'(done1), 32'(m_done[1]));
        check("wrap_lerr", 32'(err1),  32'(m_lerr[1]));
    endtask

    initial begin
        logic [15:0] v;
        int          p;

        cyc(1, 0, 16'h0, 0);
        cyc(1, 1, 16'h0042, 1);
        check("rst_out", 32'(out0), 32'h0);
        check("rst_zero", 32'(zero0), 32'h1);

        // Countdown from 3, then sit at zero.
        cyc(0, 1, 16'h0003, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 16'h0, 1);

        cyc(0, 1, 16'h1000, 0);
        cyc(0, 0, 16'h0, 1);
        check("borrow3", 32'(out0), 32'h0999);
        cyc(0, 1, 16'h0100, 0);
        cyc(0, 0, 16'h0, 1);
        check("borrow2", 32'(out0), 32'h0099);

        cyc(0, 1, 16'h0A12, 1);
        check("rej_hold", 32'(out0), 32'h0099);
        check("rej_err", 32'(err0), 32'h1);
        cyc(0, 1, 16'h0012, 0);
        check("reload", 32'(out0), 32'h0012);

        // Paused cycles do not count toward the terminal count.
        cyc(0, 1, 16'h0005, 0);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);
        check("pause_nodone", 32'(done0), 32'h0);
        cyc(0, 0, 16'h0, 1);
        check("pause_done", 32'(done0), 32'h1);

        cyc(0, 1, 16'h0001, 0);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);
        check("wrap_9999", 32'(out1), 32'h9999);
        cyc(0, 0, 16'h0, 1);
        check("wrap_9998", 32'(out1), 32'h9998);

        // Load beats the terminal step.
        cyc(0, 1, 16'h0002, 0);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 1, 16'h0042, 1);
        check("ld_win_out", 32'(out0), 32'h0042);
        check("ld_win_done", 32'(done0), 32'h0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 1);
        check("at_37", 32'(out0), 32'h0037);
        cyc(1, 1, 16'h0055, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 1);
        check("idle_out", 32'(out0), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            p = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 0) v = to_bcd($urandom_range(0, 12));
            else if ($urandom_range(0, 1) == 0) v = to_bcd($urandom_range(0, MAXV));
            else v = 16'($urandom);
            cyc(p < 2, p >= 2 && p < 12, v, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
